// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with registered blank/sync decode
// and frame bookkeeping. All state advances only on pix_en edges.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic       line_end,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] hc, vc, hc_nxt, vc_nxt;
    logic       h_wrap, v_wrap, f_wrap;

    always_comb begin
        h_wrap = (hc == H_LAST);
        v_wrap = (vc == V_LAST);
        f_wrap = h_wrap && v_wrap;
        hc_nxt = h_wrap ? 10'd0 : hc + 10'd1;
        vc_nxt = vc;
        if (h_wrap)
            vc_nxt = v_wrap ? 10'd0 : vc + 10'd1;
    end

    // Decode from next-state counts so the registered flags line up with
    // the DrawX/DrawY they describe, with no one-pixel skew.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc          <= '0;
            vc          <= '0;
            frame_count <= '0;
            blank       <= 1'b0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            hc          <= hc_nxt;
            vc          <= vc_nxt;
            blank       <= (hc_nxt < H_VIS) && (vc_nxt < V_VIS);
            hs          <= !((hc_nxt >= HS_START) && (hc_nxt < HS_END));
            vs          <= !((vc_nxt >= VS_START) && (vc_nxt < VS_END));
            frame_start <= f_wrap;
            if (f_wrap)
                frame_count <= frame_count + 8'd1;
        end else begin
            frame_start <= 1'b0;
        end
    end

    assign DrawX    = hc;
    assign DrawY    = vc;
    assign line_end = (hc == H_LAST) && pix_en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line-level timing, plus a
// small-raster instance (16x12) so whole-frame and 256-frame runs stay short.
module tb_vga_timing_gen;

    logic vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int n_chk  = 0;
    int n_pass = 0;

    // default-timing instance
    logic       rst_d, en_d;
    logic [9:0] dx_d, dy_d;
    logic       blank_d, hs_d, vs_d, fs_d, le_d;
    logic [7:0] fc_d;

    vga_timing_gen u_dut_d (
        .vga_clk(vga_clk), .reset(rst_d), .pix_en(en_d),
        .DrawX(dx_d), .DrawY(dy_d), .blank(blank_d), .hs(hs_d), .vs(vs_d),
        .frame_start(fs_d), .line_end(le_d), .frame_count(fc_d)
    );

    // small raster: H 8+2+3+3=16 (hs low 10..12), V 6+2+2+2=12 (vs low 8..9)
    logic       rst_s, en_s;
    logic [9:0] dx_s, dy_s;
    logic       blank_s, hs_s, vs_s, fs_s, le_s;
    logic [7:0] fc_s;

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) u_dut_s (
        .vga_clk(vga_clk), .reset(rst_s), .pix_en(en_s),
        .DrawX(dx_s), .DrawY(dy_s), .blank(blank_s), .hs(hs_s), .vs(vs_s),
        .frame_start(fs_s), .line_end(le_s), .frame_count(fc_s)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // inputs change and outputs are sampled 1ns after the rising edge
    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    // small-instance reference model state
    int sx, sy, sfc, s_fs_cnt, s_vs_low;

    task automatic s_adv_check();
        int nx, ny;
        bit wrap;
        wrap = (sx == 15) && (sy == 11);
        nx = (sx == 15) ? 0 : sx + 1;
        ny = (sx == 15) ? ((sy == 11) ? 0 : sy + 1) : sy;
        if (wrap) sfc = (sfc + 1) % 256;
        sx = nx; sy = ny;
        step();
        chk("s_x",  dx_s, sx);
        chk("s_y",  dy_s, sy);
        chk("s_blank", blank_s, (sx < 8 && sy < 6) ? 1 : 0);
        chk("s_hs", hs_s, (sx >= 10 && sx < 13) ? 0 : 1);
        chk("s_vs", vs_s, (sy >= 8 && sy < 10) ? 0 : 1);
        chk("s_fs", fs_s, wrap ? 1 : 0);
        chk("s_fc", fc_s, sfc);
        if (fs_s) s_fs_cnt++;
        if (!vs_s) s_vs_low++;
    endtask

    initial begin
        int hs_low, ex, ey;
        bit en;
        rst_d = 1'b1; en_d = 1'b1;
        rst_s = 1'b1; en_s = 1'b1;

        // reset for 3 cycles (pix_en high, reset must win)
        repeat (3) step();
        chk("rst_x", dx_d, 0);
        chk("rst_y", dy_d, 0);
        chk("rst_blank", blank_d, 0);
        chk("rst_hs", hs_d, 1);
        chk("rst_vs", vs_d, 1);
        chk("rst_fs", fs_d, 0);
        chk("rst_fc", fc_d, 0);

        // one full line at pix_en=1
        rst_d = 1'b0;
        hs_low = 0;
        for (int k = 1; k < 800; k++) begin
            step();
            chk("l_x", dx_d, k);
            chk("l_y", dy_d, 0);
            chk("l_blank", blank_d, (k < 640) ? 1 : 0);
            chk("l_hs", hs_d, (k >= 656 && k < 752) ? 0 : 1);
            chk("l_le", le_d, (k == 799) ? 1 : 0);
            chk("l_fs", fs_d, 0);
            if (!hs_d) hs_low++;
        end
        chk("l_hs_low_cnt", hs_low, 96);
        step();
        chk("l_wrap_x", dx_d, 0);
        chk("l_wrap_y", dy_d, 1);
        chk("l_wrap_blank", blank_d, 1);
        chk("l_wrap_fs", fs_d, 0);

        // pix_en toggling 1,0,1,0: one line takes 1600 edges
        ex = 0; ey = 1;
        for (int i = 0; i < 1600; i++) begin
            en = (i % 2 == 0);
            en_d = en;
            if (en) begin
                if (ex == 799) begin ex = 0; ey++; end
                else ex++;
            end
            step();
            chk("t_x", dx_d, ex);
            chk("t_y", dy_d, ey);
            chk("t_blank", blank_d, (ex < 640 && ey < 480) ? 1 : 0);
            chk("t_hs", hs_d, (ex >= 656 && ex < 752) ? 0 : 1);
            chk("t_le", le_d, (ex == 799 && en) ? 1 : 0);
        end
        chk("t_end_x", dx_d, 0);
        chk("t_end_y", dy_d, 2);

        // mid-line reset at DrawX=700 (inside hsync)
        en_d = 1'b1;
        repeat (700) step();
        chk("m_pre_x", dx_d, 700);
        chk("m_pre_hs", hs_d, 0);
        rst_d = 1'b1;
        step();
        chk("m_x", dx_d, 0);
        chk("m_y", dy_d, 0);
        chk("m_blank", blank_d, 0);
        chk("m_hs", hs_d, 1);
        chk("m_fs", fs_d, 0);
        rst_d = 1'b0;
        step();
        chk("m_exit_x", dx_d, 1);
        chk("m_exit_blank", blank_d, 1);
        chk("m_exit_fs", fs_d, 0);

        // small raster: reset exit, then 256 full frames
        rst_s = 1'b0; en_s = 1'b1;
        sx = 0; sy = 0; sfc = 0; s_fs_cnt = 0; s_vs_low = 0;
        s_adv_check();
        chk("s_first_blank", blank_s, 1);
        for (int i = 1; i < 192; i++) s_adv_check();
        chk("s_f1_fc", fc_s, 1);
        chk("s_f1_vs_low", s_vs_low, 32);
        for (int i = 0; i < 255 * 192; i++) s_adv_check();
        chk("s_fs_pulses", s_fs_cnt, 256);
        chk("s_fc_wrap", fc_s, 0);

        // pix_en low right after a wrap: frame_start drops, state holds
        en_s = 1'b0;
        repeat (3) begin
            step();
            chk("h_fs", fs_s, 0);
            chk("h_x", dx_s, 0);
            chk("h_y", dy_s, 0);
            chk("h_blank", blank_s, 1);
            chk("h_fc", fc_s, 0);
        end

        // run to frame_count=5 at (11,5) in hsync, then reset mid-frame
        en_s = 1'b1;
        for (int i = 0; i < 5 * 192 + 5 * 16 + 11; i++) s_adv_check();
        chk("r_pre_x", dx_s, 11);
        chk("r_pre_y", dy_s, 5);
        chk("r_pre_fc", fc_s, 5);
        chk("r_pre_hs", hs_s, 0);
        rst_s = 1'b1;
        step();
        chk("r_x", dx_s, 0);
        chk("r_y", dy_s, 0);
        chk("r_fc", fc_s, 0);
        chk("r_hs", hs_s, 1);
        chk("r_vs", vs_s, 1);
        chk("r_blank", blank_s, 0);
        chk("r_fs", fs_s, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- H_VISIBLE, 640, active pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_VISIBLE, 480, active lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).

REQ-002 Ports, one per line: name, direction, width, meaning.
- vga_clk, in, 1, sole clock; all state updates on its rising edge.
- reset, in, 1, synchronous, active-high.
- pix_en, in, 1, pixel-advance qualifier; 1 = advance one pixel this edge.
- DrawX, out, 10, current horizontal count (pixel column).
- DrawY, out, 10, current vertical count (line).
- blank, out, 1, 1 = visible pixel (draw), 0 = blanking interval.
- hs, out, 1, horizontal sync, active-low.
- vs, out, 1, vertical sync, active-low.
- frame_start, out, 1, one-cycle pulse when the counters wrap to (0,0).
- line_end, out, 1, high while DrawX = H_TOTAL-1 and pix_en = 1.
- frame_count, out, 8, completed-frame counter.

REQ-003 One clock (vga_clk); reset is synchronous and active-high.

Function
REQ-004 H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (default 525).
REQ-005 Horizontal counter hc: range 0..H_TOTAL-1; increments by 1 on each edge with pix_en=1; wraps H_TOTAL-1 -> 0.
REQ-006 Vertical counter vc: range 0..V_TOTAL-1; increments only on an edge where hc wraps; wraps V_TOTAL-1 -> 0 on the same edge that hc wraps.
REQ-007 pix_en=0: hc, vc, frame_count, hs, vs and blank all hold their values; frame_start = 0.
REQ-008 DrawX = hc and DrawY = vc, driven directly from the state registers, with zero latency relative to them.
REQ-009 blank, hs and vs are registered. Each is computed from the next-state counter values, so in every cycle it decodes the DrawX/DrawY presented in that same cycle (no skew).
REQ-010 blank = 1 iff hc < H_VISIBLE and vc < V_VISIBLE.
REQ-011 hs = 0 iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (default 656..751); otherwise hs = 1.
REQ-012 vs = 0 iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (default 490..491); otherwise vs = 1.
REQ-013 frame_start is registered. It is 1 for exactly one cycle, the cycle in which (hc,vc) first equals (0,0) after a wrap from (H_TOTAL-1, V_TOTAL-1).
REQ-014 frame_count increments, modulo 256, on the same edge as the (H_TOTAL-1, V_TOTAL-1) -> (0,0) wrap; 255 -> 0 with no flag.
REQ-015 line_end is combinational: (hc == H_TOTAL-1) and pix_en.
REQ-016 Counter widths: 10 bits each. Default totals fit; parameter sets with H_TOTAL or V_TOTAL > 1024 are unsupported.

Reset
REQ-017 While reset is sampled high: hc = 0, vc = 0, frame_count = 0, blank = 0, hs = 1, vs = 1, frame_start = 0.
REQ-018 Reset overrides pix_en. Reset asserted mid-frame returns all state to REQ-017 values on that edge, with no frame_start pulse and no frame_count increment.
REQ-019 First edge with reset = 0 and pix_en = 1: hc -> 1, vc stays 0, blank -> 1. Pixel (0,0) of the first post-reset frame is blanked. No frame_start pulse on reset exit.

Verification
REQ-020 The bench SHALL cover at least the following directed scenarios.
- Reset 3 cycles, then pix_en = 1 constant -> DrawX sequence 0,1,2...; blank = 1 from DrawX = 1 through 639; blank = 0 at DrawX = 640.
- pix_en = 1 for one full line -> hs = 0 for exactly 96 cycles, DrawX 656..751; line_end = 1 only at DrawX = 799; DrawY 0 -> 1 on the next edge.
- pix_en = 1 for a full frame (420000 cycles) -> vs = 0 for exactly 1600 cycles, DrawY 490..491; frame_start = 1 for one cycle at (0,0); frame_count = 1.
- pix_en toggling 1,0,1,0 (50 MHz-style) -> counters advance every other edge; a full line takes 1600 edges; hs/vs/blank stay aligned with DrawX/DrawY.
- Reset asserted at DrawX = 700, DrawY = 300 with frame_count = 5 -> next cycle DrawX = 0, DrawY = 0, frame_count = 0, hs = 1, vs = 1, blank = 0, frame_start = 0.
- 256 consecutive frames -> frame_count wraps 255 -> 0; frame_start pulses 256 times, each exactly one cycle long.
